// File: rtl/gate_sweep_checker_pkg.sv
// gate_sweep_checker_pkg
//   Shared definitions for the gate sweep checker: 3-bit state encodings,
//   the FSM state type, a constant clog2 helper and the truth-table lookup
//   expect_of(). No ports.
package gate_sweep_checker_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_DRIVE  = 3'd1;
  localparam logic [2:0] ST_WAIT   = 3'd2;
  localparam logic [2:0] ST_SAMPLE = 3'd3;
  localparam logic [2:0] ST_DONE   = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE   = ST_IDLE,
    S_DRIVE  = ST_DRIVE,
    S_WAIT   = ST_WAIT,
    S_SAMPLE = ST_SAMPLE,
    S_DONE   = ST_DONE
  } state_t;

  // Widest table supported: 2**8 vectors x 4 outputs.
  localparam int TBL_W   = 1024;
  localparam int OUT_MAX = 4;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  // Expected outputs for vector v, zero-extended to OUT_MAX bits.
  function automatic logic [OUT_MAX-1:0] expect_of(input logic [TBL_W-1:0] tbl,
                                                   input int v,
                                                   input int n_out);
    logic [TBL_W-1:0]   sh;
    logic [OUT_MAX-1:0] m;
    sh = tbl >> (v * n_out);
    m  = OUT_MAX'((32'd1 << n_out) - 32'd1);
    return sh[OUT_MAX-1:0] & m;
  endfunction

endpackage

// File: rtl/gate_sweep_checker_if.sv
// gate_sweep_checker_if
//   Control/status bundle of the gate sweep checker.
//   master: drives start/loop/abort, observes status.
//   slave : the checker; observes start/loop/abort, drives busy, done, pass,
//           err_count, fail_valid, fail_vec, fail_got.
interface gate_sweep_checker_if #(
  parameter int N_IN  = 3,
  parameter int N_OUT = 1
);
  logic             start;
  logic             loop;
  logic             abort;
  logic             busy;
  logic             done;
  logic             pass;
  logic [N_IN:0]    err_count;
  logic             fail_valid;
  logic [N_IN-1:0]  fail_vec;
  logic [N_OUT-1:0] fail_got;

  modport master (
    output start, loop, abort,
    input  busy, done, pass, err_count, fail_valid, fail_vec, fail_got
  );

  modport slave (
    input  start, loop, abort,
    output busy, done, pass, err_count, fail_valid, fail_vec, fail_got
  );
endinterface

// File: rtl/gate_sweep_checker_timer.sv
// gsc_settle_timer
//   4-bit loadable down-counter with a zero flag. Decrement stops at zero.
//   clk, rst_n   : clock, async active-low reset
//   i_load       : load i_load_val (wins over i_dec)
//   i_load_val   : value to load
//   i_dec        : decrement by one when not already zero
//   o_zero       : count == 0
module gsc_settle_timer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_load,
  input  logic [3:0] i_load_val,
  input  logic       i_dec,
  output logic       o_zero
);

  logic [3:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= 4'd0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec && (r_count != 4'd0)) begin
      r_count <= r_count - 4'd1;
    end
  end

  assign o_zero = (r_count == 4'd0);

endmodule

// File: rtl/gate_sweep_checker.sv
// gate_sweep_checker
//   Exhaustive stimulus/response checker for a small combinational gate.
//   Walks o_x_out over every input vector, lets each settle for SETTLE
//   cycles, samples i_dut_a and compares it with the EXPECTED truth table.
//   clk, rst_n : clock, async active-low reset
//   ctl        : control/status interface (slave side)
//   o_x_out    : stimulus to the gate under test
//   i_dut_a    : gate outputs, synchronous to clk
//
//   state  | meaning
//   IDLE   | waiting for start
//   DRIVE  | x_out applied, settle timer loaded
//   WAIT   | settle timer counting down
//   SAMPLE | dut_a compared, vector advanced
//   DONE   | sweep finished, results held
module gate_sweep_checker
  import gate_sweep_checker_pkg::*;
#(
  parameter int N_IN   = 3,
  parameter int N_OUT  = 1,
  parameter int SETTLE = 2,
  parameter logic [(2**N_IN)*N_OUT-1:0] EXPECTED = 8'h01
) (
  input  logic              clk,
  input  logic              rst_n,
  gate_sweep_checker_if.slave ctl,
  output logic [N_IN-1:0]   o_x_out,
  input  logic [N_OUT-1:0]  i_dut_a
);

  localparam int               EW        = clog2(2**N_IN) + 1;
  localparam logic [TBL_W-1:0] TBL       = TBL_W'(EXPECTED);
  localparam logic [3:0]       SETTLE_LD = (SETTLE > 0) ? 4'(SETTLE - 1) : 4'd0;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [N_IN-1:0]  r_x;
  logic [EW-1:0]    r_err;
  logic             r_done;
  logic             r_fail_valid;
  logic [N_IN-1:0]  r_fail_vec;
  logic [N_OUT-1:0] r_fail_got;

  logic             w_tmr_load;
  logic             w_tmr_dec;
  logic             w_tmr_zero;
  logic             w_last;
  logic             w_mismatch;
  logic [OUT_MAX-1:0] w_exp;

  gsc_settle_timer u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_tmr_load),
    .i_load_val (SETTLE_LD),
    .i_dec      (w_tmr_dec),
    .o_zero     (w_tmr_zero)
  );

  assign w_last     = &r_x;
  assign w_exp      = expect_of(TBL, int'(32'(r_x)), N_OUT);
  assign w_mismatch = (w_exp != OUT_MAX'(i_dut_a));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_tmr_load  = 1'b0;
    w_tmr_dec   = 1'b0;
    if (ctl.abort) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (ctl.start) w_state_nxt = S_DRIVE;
        end
        S_DRIVE: begin
          w_tmr_load  = 1'b1;
          w_state_nxt = (SETTLE > 0) ? S_WAIT : S_SAMPLE;
        end
        S_WAIT: begin
          if (w_tmr_zero) w_state_nxt = S_SAMPLE;
          else            w_tmr_dec   = 1'b1;
        end
        S_SAMPLE: begin
          if (!w_last || ctl.loop) w_state_nxt = S_DRIVE;
          else                     w_state_nxt = S_DONE;
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x          <= '0;
      r_err        <= '0;
      r_done       <= 1'b0;
      r_fail_valid <= 1'b0;
      r_fail_vec   <= '0;
      r_fail_got   <= '0;
    end else if (ctl.abort) begin
      // Partial err/fail results stay visible after an abort.
      r_x    <= '0;
      r_done <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (ctl.start) begin
            r_x          <= '0;
            r_err        <= '0;
            r_done       <= 1'b0;
            r_fail_valid <= 1'b0;
            r_fail_vec   <= '0;
            r_fail_got   <= '0;
          end
        end
        S_DRIVE: begin
          // done set here means a looped sweep just wrapped: the previous
          // sweep's results were shown for this one cycle, now clear them.
          if (r_done) begin
            r_done       <= 1'b0;
            r_err        <= '0;
            r_fail_valid <= 1'b0;
            r_fail_vec   <= '0;
            r_fail_got   <= '0;
          end
        end
        S_SAMPLE: begin
          if (w_mismatch) begin
            if (!(&r_err)) r_err <= r_err + EW'(1);
            if (!r_fail_valid) begin
              r_fail_valid <= 1'b1;
              r_fail_vec   <= r_x;
              r_fail_got   <= i_dut_a;
            end
          end
          if (!w_last) begin
            r_x <= r_x + N_IN'(1);
          end else begin
            r_done <= 1'b1;
            if (ctl.loop) r_x <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_x_out        = r_x;
  assign ctl.busy       = (r_state == S_DRIVE) || (r_state == S_WAIT) || (r_state == S_SAMPLE);
  assign ctl.done       = r_done;
  assign ctl.pass       = r_done && (r_err == '0);
  assign ctl.err_count  = r_err;
  assign ctl.fail_valid = r_fail_valid;
  assign ctl.fail_vec   = r_fail_vec;
  assign ctl.fail_got   = r_fail_got;

endmodule

// File: tb/tb_gate_sweep_checker.sv
module tb_gate_sweep_checker;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  gate_sweep_checker_if #(.N_IN(3), .N_OUT(1)) c0 ();
  gate_sweep_checker_if #(.N_IN(2), .N_OUT(2)) c1 ();

  logic [2:0] x0;
  logic       dut0;
  logic [1:0] x1;
  logic [1:0] dut1;
  logic [7:0] mask0 = 8'h00;
  logic [1:0] mask1 [4];

  // Gate models: NOR3 and half adder {c,s}, each with per-vector fault flips.
  always_comb dut0 = (x0 == 3'd0) ^ mask0[x0];
  always_comb dut1 = (2'(x1[1]) + 2'(x1[0])) ^ mask1[x1];

  gate_sweep_checker u_dut0 (
    .clk(clk), .rst_n(rst_n), .ctl(c0), .o_x_out(x0), .i_dut_a(dut0));

  gate_sweep_checker #(.N_IN(2), .N_OUT(2), .SETTLE(0), .EXPECTED(8'b10_01_01_00)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .ctl(c1), .o_x_out(x1), .i_dut_a(dut1));

  // Reference results for the NOR3 gate given a fault mask.
  function automatic int first_set(input logic [7:0] m);
    for (int v = 0; v < 8; v++) if (m[v]) return v;
    return 0;
  endfunction

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic run0(input int mid, output int n, output int seqe);
    @(posedge clk); #1 c0.start = 1'b1;
    @(posedge clk); #1 c0.start = 1'b0;
    n = 0; seqe = 0;
    while (c0.busy && n < 400) begin
      if (int'(x0) != n / 4) seqe++;
      c0.start = (n == mid);
      step(); n++;
    end
    c0.start = 1'b0;
  endtask

  task automatic run1(output int n, output int seqe);
    @(posedge clk); #1 c1.start = 1'b1;
    @(posedge clk); #1 c1.start = 1'b0;
    n = 0; seqe = 0;
    while (c1.busy && n < 400) begin
      if (int'(x1) != n / 2) seqe++;
      step(); n++;
    end
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if ({c0.busy, c0.done, c0.pass, c0.err_count, c0.fail_valid, c0.fail_vec, c0.fail_got, x0} !== '0) begin
      failures++; $display("FAIL reset_dut0 got=%0h exp=0",
        {c0.busy, c0.done, c0.pass, c0.err_count, c0.fail_valid, c0.fail_vec, c0.fail_got, x0});
    end
    checks++;
    if ({c1.busy, c1.done, c1.err_count, c1.fail_valid, c1.fail_vec, c1.fail_got, x1} !== '0) begin
      failures++; $display("FAIL reset_dut1 got=%0h exp=0",
        {c1.busy, c1.done, c1.err_count, c1.fail_valid, c1.fail_vec, c1.fail_got, x1});
    end
    @(negedge clk); rst_n = 1'b1;
    step();
  endtask

  task automatic test_clean();
    int n, seqe;
    mask0 = 8'h00;
    run0(-1, n, seqe);
    checks++; if (n !== 32) begin failures++; $display("FAIL clean_cycles got=%0d exp=32", n); end
    checks++; if (seqe !== 0) begin failures++; $display("FAIL clean_xseq got=%0d exp=0", seqe); end
    checks++; if ({c0.done, c0.pass, c0.fail_valid} !== 3'b110) begin
      failures++; $display("FAIL clean_flags got=%b exp=110", {c0.done, c0.pass, c0.fail_valid}); end
    checks++; if (c0.err_count !== 4'd0) begin failures++; $display("FAIL clean_err got=%0d exp=0", c0.err_count); end
    checks++; if (x0 !== 3'd7) begin failures++; $display("FAIL clean_xhold got=%0d exp=7", x0); end
  endtask

  task automatic test_stuck0();
    int n, seqe;
    mask0 = 8'h01;
    run0(-1, n, seqe);
    checks++; if (c0.err_count !== 4'd1) begin failures++; $display("FAIL stuck_err got=%0d exp=1", c0.err_count); end
    checks++; if ({c0.fail_valid, c0.fail_vec, c0.fail_got} !== 5'b1_000_0) begin
      failures++; $display("FAIL stuck_fail got=%b exp=10000", {c0.fail_valid, c0.fail_vec, c0.fail_got}); end
    checks++; if ({c0.done, c0.pass} !== 2'b10) begin
      failures++; $display("FAIL stuck_pass got=%b exp=10", {c0.done, c0.pass}); end
  endtask

  task automatic test_restart_from_done();
    int n;
    mask0 = 8'h00;
    @(posedge clk); #1 c0.start = 1'b1;
    @(posedge clk); #1 c0.start = 1'b0;
    checks++; if ({c0.busy, c0.done, c0.err_count, c0.fail_valid} !== 7'b1_0_0000_0) begin
      failures++; $display("FAIL restart_clear got=%b exp=1000000",
        {c0.busy, c0.done, c0.err_count, c0.fail_valid}); end
    n = 0;
    while (c0.busy && n < 400) begin step(); n++; end
    checks++; if ({n == 32, c0.pass} !== 2'b11) begin
      failures++; $display("FAIL restart_sweep got=cycles%0d pass%b exp=cycles32 pass1", n, c0.pass); end
  endtask

  task automatic test_half_adder();
    int n, seqe;
    for (int v = 0; v < 4; v++) mask1[v] = 2'b00;
    mask1[2] = 2'b10;
    run1(n, seqe);
    checks++; if (n !== 8) begin failures++; $display("FAIL ha_cycles got=%0d exp=8", n); end
    checks++; if (seqe !== 0) begin failures++; $display("FAIL ha_xseq got=%0d exp=0", seqe); end
    checks++; if ({c1.err_count, c1.fail_vec, c1.fail_got, c1.pass} !== {3'd1, 2'b10, 2'b11, 1'b0}) begin
      failures++; $display("FAIL ha_result got=%b exp=%b",
        {c1.err_count, c1.fail_vec, c1.fail_got, c1.pass}, {3'd1, 2'b10, 2'b11, 1'b0}); end
  endtask

  task automatic test_random();
    int n, seqe, exp_err, fv;
    for (int it = 0; it < 6; it++) begin
      mask0 = 8'($urandom);
      run0(-1, n, seqe);
      exp_err = $countones(mask0);
      fv = first_set(mask0);
      checks++; if ({n, seqe} !== {32'd32, 32'd0}) begin
        failures++; $display("FAIL rnd0_timing it=%0d got=cycles%0d seq%0d exp=cycles32 seq0", it, n, seqe); end
      checks++; if (int'(c0.err_count) !== exp_err || c0.pass !== (exp_err == 0)) begin
        failures++; $display("FAIL rnd0_err it=%0d mask=%h got=%0d exp=%0d", it, mask0, c0.err_count, exp_err); end
      if (exp_err != 0) begin
        checks++; if ({c0.fail_valid, int'(c0.fail_vec), c0.fail_got} !== {1'b1, fv, fv != 0}) begin
          failures++; $display("FAIL rnd0_first it=%0d got=v%0d g%b exp=v%0d g%b", it,
            c0.fail_vec, c0.fail_got, fv, fv != 0); end
      end
    end
    for (int it = 0; it < 4; it++) begin
      int first;
      logic [1:0] got;
      exp_err = 0; first = -1; got = '0;
      for (int v = 0; v < 4; v++) begin
        mask1[v] = 2'($urandom);
        if (mask1[v] != 0) begin
          exp_err++;
          if (first < 0) begin first = v; got = 2'($countones(v)) ^ mask1[v]; end
        end
      end
      run1(n, seqe);
      checks++; if (int'(c1.err_count) !== exp_err || n !== 8) begin
        failures++; $display("FAIL rnd1_err it=%0d got=%0d/%0dcyc exp=%0d/8cyc", it, c1.err_count, n, exp_err); end
      if (first >= 0) begin
        checks++; if ({int'(c1.fail_vec), c1.fail_got} !== {first, got}) begin
          failures++; $display("FAIL rnd1_first it=%0d got=v%0d g%b exp=v%0d g%b", it,
            c1.fail_vec, c1.fail_got, first, got); end
      end
    end
  endtask

  task automatic test_loop();
    int n;
    mask0 = 8'hFF;
    c0.loop = 1'b1;
    @(posedge clk); #1 c0.start = 1'b1;
    @(posedge clk); #1 c0.start = 1'b0;
    n = 0;
    for (int s = 0; s < 3; s++) begin
      while (!c0.done && n < 100) begin step(); n++; end
      checks++; if ({n == 32, c0.err_count, c0.busy} !== {1'b1, 4'd8, 1'b1}) begin
        failures++; $display("FAIL loop_wrap s=%0d got=cycles%0d err%0d busy%b exp=cycles32 err8 busy1",
          s, n, c0.err_count, c0.busy); end
      if (s == 2) c0.loop = 1'b0;
      n = 0;
      step(); n++;
      checks++; if ({c0.done, c0.err_count, c0.fail_valid, x0} !== {1'b0, 4'd0, 1'b0, 3'd0}) begin
        failures++; $display("FAIL loop_clear s=%0d got=d%b e%0d f%b x%0d exp=d0 e0 f0 x0",
          s, c0.done, c0.err_count, c0.fail_valid, x0); end
    end
    while (!c0.done && n < 100) begin step(); n++; end
    step(); step();
    checks++; if ({n == 32, c0.done, c0.busy, c0.err_count} !== {1'b1, 1'b1, 1'b0, 4'd8}) begin
      failures++; $display("FAIL loop_stop got=cycles%0d d%b b%b e%0d exp=cycles32 d1 b0 e8",
        n, c0.done, c0.busy, c0.err_count); end
  endtask

  task automatic test_abort();
    int n, seqe, exp_err;
    mask0 = 8'($urandom) | 8'h02;
    exp_err = $countones(mask0[2:0]);
    @(posedge clk); #1 c0.start = 1'b1;
    @(posedge clk); #1 c0.start = 1'b0;
    for (int k = 0; k < 12; k++) step();
    c0.abort = 1'b1;
    step();
    c0.abort = 1'b0;
    checks++; if ({c0.busy, c0.done, x0} !== 5'b0) begin
      failures++; $display("FAIL abort_idle got=%b exp=00000", {c0.busy, c0.done, x0}); end
    checks++; if (int'(c0.err_count) !== exp_err || c0.fail_valid !== 1'b1 || int'(c0.fail_vec) !== first_set(mask0)) begin
      failures++; $display("FAIL abort_partial got=e%0d v%0d exp=e%0d v%0d", c0.err_count, c0.fail_vec,
        exp_err, first_set(mask0)); end
    step();
    c0.start = 1'b1; c0.abort = 1'b1;
    step();
    c0.start = 1'b0; c0.abort = 1'b0;
    step();
    checks++; if ({c0.busy, x0} !== 4'b0) begin
      failures++; $display("FAIL abort_beats_start got=%b exp=0000", {c0.busy, x0}); end
    mask0 = 8'h00;
    run0(-1, n, seqe);
    checks++; if ({n == 32, seqe == 0, c0.pass, c0.err_count} !== {3'b111, 4'd0}) begin
      failures++; $display("FAIL abort_rerun got=cycles%0d seq%0d pass%b err%0d exp=cycles32 seq0 pass1 err0",
        n, seqe, c0.pass, c0.err_count); end
  endtask

  task automatic test_async_reset();
    int n, seqe;
    mask0 = 8'h10;
    @(posedge clk); #1 c0.start = 1'b1;
    @(posedge clk); #1 c0.start = 1'b0;
    for (int k = 0; k < 20; k++) step();
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({c0.busy, c0.done, c0.err_count, c0.fail_valid, c0.fail_vec, x0} !== '0) begin
      failures++; $display("FAIL async_reset got=%b exp=0",
        {c0.busy, c0.done, c0.err_count, c0.fail_valid, c0.fail_vec, x0}); end
    @(negedge clk); rst_n = 1'b1;
    mask0 = 8'h00;
    run0(10, n, seqe);
    checks++; if ({n == 32, seqe == 0, c0.pass} !== 3'b111) begin
      failures++; $display("FAIL busy_start_ignored got=cycles%0d seq%0d pass%b exp=cycles32 seq0 pass1",
        n, seqe, c0.pass); end
  endtask

  initial begin
    c0.start = 1'b0; c0.loop = 1'b0; c0.abort = 1'b0;
    c1.start = 1'b0; c1.loop = 1'b0; c1.abort = 1'b0;
    for (int v = 0; v < 4; v++) mask1[v] = 2'b00;
    test_reset();
    test_clean();
    test_stuck0();
    test_restart_from_done();
    test_half_adder();
    test_random();
    test_loop();
    test_abort();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

endmodule
